// File: rtl/riscv_lsu_pkg.sv
// Types and helpers shared by the load/store unit and its alignment datapath.
`include "riscv_configs.v"

package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = `LSU_ST_IDLE,
        ST_ACC1 = `LSU_ST_ACC1,
        ST_ACC2 = `LSU_ST_ACC2,
        ST_RSP  = `LSU_ST_RSP
    } lsu_state_t;

    localparam logic [1:0] SZ_B   = `SZ_B;
    localparam logic [1:0] SZ_H   = `SZ_H;
    localparam logic [1:0] SZ_W   = `SZ_W;
    localparam logic [1:0] SZ_RSV = `SZ_RSV;

    // Byte-lane mask of an access before it is shifted to its address offset.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            SZ_W:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_configs.v
// Shared configuration constants for the RISC-V core: data width, data-memory
// address width, access-size encodings and load/store unit state encodings.
`ifndef RISCV_CONFIGS_V
`define RISCV_CONFIGS_V

`define XLEN          32
`define DMEM_ADDR_BIT 10

`define SZ_B   2'b00
`define SZ_H   2'b01
`define SZ_W   2'b10
`define SZ_RSV 2'b11

`define LSU_ST_IDLE 2'd0
`define LSU_ST_ACC1 2'd1
`define LSU_ST_ACC2 2'd2
`define LSU_ST_RSP  2'd3

`endif

// File: rtl/riscv_lsu_align.sv
// Combinational alignment: byte enables and store data spread over two words,
// and load data extracted from a two-word window then zero/sign extended.
`include "riscv_configs.v"

module riscv_lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic [1:0]            size,
    input  logic [1:0]            off,
    input  logic                  is_unsigned,
    input  logic [XLEN-1:0]       wdata,
    input  logic [XLEN-1:0]       lo_word,
    input  logic [XLEN-1:0]       hi_word,
    output logic [2*XLEN/8-1:0]   byte_sel,
    output logic [2*XLEN-1:0]     st_data,
    output logic [XLEN-1:0]       ld_data
);

    logic [XLEN-1:0] ld_win;

    always_comb begin
        byte_sel = {{(XLEN/8){1'b0}}, size_mask(size)} << off;
        st_data  = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
        // Lower word of {hi,lo} after dropping the offset bytes.
        ld_win   = XLEN'({hi_word, lo_word} >> {off, 3'b000});
        ld_data  = '0;
        case (size)
            SZ_B:    ld_data = {{(XLEN-8){~is_unsigned & ld_win[7]}}, ld_win[7:0]};
            SZ_H:    ld_data = {{(XLEN-16){~is_unsigned & ld_win[15]}}, ld_win[15:0]};
            SZ_W:    ld_data = ld_win;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one request at a time, split into one or two word accesses
// when the access straddles a word boundary, then a one-cycle response.
`include "riscv_configs.v"

module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN          = `XLEN,
    parameter int DMEM_ADDR_BIT = `DMEM_ADDR_BIT
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_we,
    input  logic [1:0]               i_req_size,
    input  logic                     i_req_unsigned,
    input  logic [XLEN-1:0]          i_req_addr,
    input  logic [XLEN-1:0]          i_req_wdata,
    output logic                     o_rsp_valid,
    output logic [XLEN-1:0]          o_rsp_rdata,
    output logic                     o_rsp_err,
    output logic                     o_dmem_wr_en,
    output logic [XLEN/8-1:0]        o_dmem_byte_sel,
    output logic [DMEM_ADDR_BIT-3:0] o_dmem_addr,
    output logic [XLEN-1:0]          o_dmem_data,
    input  logic [XLEN-1:0]          i_dmem_data
);

    localparam int IW = DMEM_ADDR_BIT - 2;

    lsu_state_t state, state_n;

    logic            we_q, uns_q;
    logic [1:0]      size_q, off_q;
    logic [XLEN-1:0] wdata_q, lo_q;

    logic            accept, crossing;
    logic            we_n, uns_n;
    logic [1:0]      size_n, off_n;
    logic [XLEN-1:0] wdata_n, lo_in;
    logic [IW-1:0]   idx_n;

    logic [2*XLEN/8-1:0] sel_w;
    logic [2*XLEN-1:0]   st_w;
    logic [XLEN-1:0]     ld_w;
    logic                unused_addr_bits;

    assign o_req_ready      = (state == ST_IDLE);
    assign accept           = o_req_ready & i_req_valid;
    assign idx_n            = i_req_addr[DMEM_ADDR_BIT-1:2];
    assign unused_addr_bits = ^i_req_addr[XLEN-1:DMEM_ADDR_BIT];
    assign crossing         = ({1'b0, off_q} + size_bytes(size_q)) > 3'd4;
    // The low word comes straight from memory while in ACC1, from the capture after.
    assign lo_in            = (state == ST_ACC1) ? i_dmem_data : lo_q;

    // Fields seen by the datapath: live request on acceptance, registered copy otherwise.
    always_comb begin
        we_n    = we_q;
        uns_n   = uns_q;
        size_n  = size_q;
        off_n   = off_q;
        wdata_n = wdata_q;
        if (accept) begin
            we_n    = i_req_we;
            uns_n   = i_req_unsigned;
            size_n  = i_req_size;
            off_n   = i_req_addr[1:0];
            wdata_n = i_req_wdata;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (i_req_valid) state_n = (i_req_size == SZ_RSV) ? ST_RSP : ST_ACC1;
            ST_ACC1: state_n = crossing ? ST_ACC2 : ST_RSP;
            ST_ACC2: state_n = ST_RSP;
            ST_RSP:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    riscv_lsu_align #(.XLEN(XLEN)) u_align (
        .size        (size_n),
        .off         (off_n),
        .is_unsigned (uns_n),
        .wdata       (wdata_n),
        .lo_word     (lo_in),
        .hi_word     (i_dmem_data),
        .byte_sel    (sel_w),
        .st_data     (st_w),
        .ld_data     (ld_w)
    );

    // Memory and response outputs are registered on entry to the state that owns them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            we_q            <= 1'b0;
            uns_q           <= 1'b0;
            size_q          <= SZ_B;
            off_q           <= 2'd0;
            wdata_q         <= '0;
            lo_q            <= '0;
            o_rsp_valid     <= 1'b0;
            o_rsp_err       <= 1'b0;
            o_rsp_rdata     <= '0;
            o_dmem_wr_en    <= 1'b0;
            o_dmem_byte_sel <= '0;
            o_dmem_addr     <= '0;
            o_dmem_data     <= '0;
        end else begin
            state        <= state_n;
            we_q         <= we_n;
            uns_q        <= uns_n;
            size_q       <= size_n;
            off_q        <= off_n;
            wdata_q      <= wdata_n;
            if (state == ST_ACC1) lo_q <= i_dmem_data;
            o_rsp_valid     <= 1'b0;
            o_rsp_err       <= 1'b0;
            o_rsp_rdata     <= '0;
            o_dmem_wr_en    <= 1'b0;
            o_dmem_byte_sel <= '0;
            case (state_n)
                ST_ACC1: begin
                    o_dmem_addr     <= idx_n;
                    o_dmem_byte_sel <= sel_w[XLEN/8-1:0];
                    o_dmem_data     <= st_w[XLEN-1:0];
                    o_dmem_wr_en    <= we_n;
                end
                ST_ACC2: begin
                    o_dmem_addr     <= o_dmem_addr + {{(IW-1){1'b0}}, 1'b1};
                    o_dmem_byte_sel <= sel_w[2*XLEN/8-1:XLEN/8];
                    o_dmem_data     <= st_w[2*XLEN-1:XLEN];
                    o_dmem_wr_en    <= we_q;
                end
                ST_RSP: begin
                    o_rsp_valid <= 1'b1;
                    o_rsp_err   <= (size_n == SZ_RSV);
                    o_rsp_rdata <= we_n ? '0 : ld_w;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: byte-level memory model, per-cycle response/ready compare
// against expected queues, and directed vectors with literal expectations.
module tb_riscv_lsu;

    localparam int XLEN = 32;
    localparam int DAB  = 8;
    localparam int IW   = DAB - 2;
    localparam int NW   = 1 << IW;
    localparam int NB   = 4 * NW;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_req_valid;
    logic            o_req_ready;
    logic            i_req_we;
    logic [1:0]      i_req_size;
    logic            i_req_unsigned;
    logic [31:0]     i_req_addr;
    logic [31:0]     i_req_wdata;
    logic            o_rsp_valid;
    logic [31:0]     o_rsp_rdata;
    logic            o_rsp_err;
    logic            o_dmem_wr_en;
    logic [3:0]      o_dmem_byte_sel;
    logic [IW-1:0]   o_dmem_addr;
    logic [31:0]     o_dmem_data;
    logic [31:0]     i_dmem_data;

    riscv_lsu #(.XLEN(XLEN), .DMEM_ADDR_BIT(DAB)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_we        (i_req_we),
        .i_req_size      (i_req_size),
        .i_req_unsigned  (i_req_unsigned),
        .i_req_addr      (i_req_addr),
        .i_req_wdata     (i_req_wdata),
        .o_rsp_valid     (o_rsp_valid),
        .o_rsp_rdata     (o_rsp_rdata),
        .o_rsp_err       (o_rsp_err),
        .o_dmem_wr_en    (o_dmem_wr_en),
        .o_dmem_byte_sel (o_dmem_byte_sel),
        .o_dmem_addr     (o_dmem_addr),
        .o_dmem_data     (o_dmem_data),
        .i_dmem_data     (i_dmem_data)
    );

    // ---------------- clock / memory fixture ----------------
    always #5 i_clk = ~i_clk;

    logic [31:0] mem [0:NW-1];
    logic        set_req = 1'b0;
    logic [IW-1:0] set_idx = '0;
    logic [31:0] set_val = '0;
    int          cyc = 0;
    int          wr_cnt = 0;

    assign i_dmem_data = mem[o_dmem_addr];

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (set_req) mem[set_idx] = set_val;
        if (o_dmem_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            for (int b = 0; b < 4; b++)
                if (o_dmem_byte_sel[b]) mem[o_dmem_addr][8*b +: 8] = o_dmem_data[8*b +: 8];
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0]  model_bytes [0:NB-1];
    int          exp_acc_q[$];
    int          exp_cyc_q[$];
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    int          n_checks = 0;
    int          n_errs = 0;
    bit          chk_en = 1'b0;
    logic        busy;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_rsp_cyc;
    int          last_acc;

    logic [IW-1:0] a1_addr, a2_addr;
    logic [3:0]    a1_sel, a2_sel;
    logic [31:0]   a1_data, a2_data;
    logic          a1_we, a2_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input int idx);
        return {model_bytes[4*idx+3], model_bytes[4*idx+2], model_bytes[4*idx+1], model_bytes[4*idx]};
    endfunction

    // Reference behaviour: byte-addressed memory, little-endian, wrap inside the memory.
    task automatic model_access(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] er, output logic err, output int lat);
        int nb;
        int base;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        base = int'(addr % NB);
        er   = 32'h0;
        err  = (nb == 0);
        if (nb == 0) begin
            lat = 1;
        end else begin
            lat = ((addr % 4) + nb > 4) ? 3 : 2;
            for (int i = 0; i < nb; i++) begin
                if (we) model_bytes[(base + i) % NB] = wd[8*i +: 8];
                else    er[8*i +: 8] = model_bytes[(base + i) % NB];
            end
            if (!we && !uns && nb < 4 && er[8*nb-1]) er = er | (32'hFFFF_FFFF << (8*nb));
        end
    endtask

    always @(negedge i_clk) begin
        if (chk_en) begin
            busy = (exp_cyc_q.size() != 0) && (cyc > exp_acc_q[0]) && (cyc <= exp_cyc_q[0]);
            chk("req_ready", o_req_ready, !busy);
            if (exp_cyc_q.size() != 0 && cyc == exp_cyc_q[0]) begin
                chk("rsp_valid", o_rsp_valid, 1'b1);
                chk("rsp_rdata", o_rsp_rdata, exp_q[0]);
                chk("rsp_err", o_rsp_err, exp_err_q[0]);
                last_rdata   = o_rsp_rdata;
                last_err     = o_rsp_err;
                last_rsp_cyc = cyc;
                void'(exp_acc_q.pop_front());
                void'(exp_cyc_q.pop_front());
                void'(exp_q.pop_front());
                void'(exp_err_q.pop_front());
            end else begin
                chk("rsp_valid_idle", o_rsp_valid, 1'b0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_word(input int idx, input logic [31:0] val);
        @(negedge i_clk);
        set_req = 1'b1;
        set_idx = IW'(idx);
        set_val = val;
        for (int b = 0; b < 4; b++) model_bytes[4*idx + b] = val[8*b +: 8];
        @(posedge i_clk);
        #1 set_req = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        int guard;
        int lat;
        logic [31:0] er;
        logic er_err;
        guard = 0;
        last_rsp_cyc = -100;
        @(negedge i_clk);
        while (!o_req_ready && guard < 50) begin
            @(negedge i_clk);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", 32'd0, 32'd1);
        i_req_valid    = 1'b1;
        i_req_we       = we;
        i_req_size     = sz;
        i_req_unsigned = uns;
        i_req_addr     = addr;
        i_req_wdata    = wd;
        last_acc       = cyc;
        model_access(we, sz, uns, addr, wd, er, er_err, lat);
        exp_acc_q.push_back(last_acc);
        exp_cyc_q.push_back(last_acc + lat);
        exp_q.push_back(er);
        exp_err_q.push_back(er_err);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        a1_addr = o_dmem_addr; a1_sel = o_dmem_byte_sel; a1_data = o_dmem_data; a1_we = o_dmem_wr_en;
        @(negedge i_clk);
        a2_addr = o_dmem_addr; a2_sel = o_dmem_byte_sel; a2_data = o_dmem_data; a2_we = o_dmem_wr_en;
        guard = 0;
        while (exp_cyc_q.size() != 0 && guard < 20) begin
            @(negedge i_clk);
            guard++;
        end
        if (exp_cyc_q.size() != 0) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            exp_acc_q.delete(); exp_cyc_q.delete(); exp_q.delete(); exp_err_q.delete();
        end
    endtask

    // ---------------- directed stimulus ----------------
    logic        tv_we  [0:5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  tv_sz  [0:5] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd1};
    logic        tv_uns [0:5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] tv_adr [0:5] = '{32'h31, 32'h31, 32'h31, 32'h27, 32'h27, 32'h27};
    logic [31:0] tv_wd  [0:5] = '{32'h1234_56A5, 32'h0, 32'h0, 32'h0BAD_F00D, 32'h0, 32'h0};
    logic [31:0] tv_exp [0:5] = '{32'h0, 32'hFFFF_FFA5, 32'h0000_00A5, 32'h0, 32'h0BAD_F00D, 32'h0000_F00D};

    initial begin
        int w0;
        i_rst = 1'b1;
        i_req_valid = 1'b0; i_req_we = 1'b0; i_req_size = 2'd0; i_req_unsigned = 1'b0;
        i_req_addr = '0; i_req_wdata = '0;
        for (int i = 0; i < NW; i++) set_word(i, $urandom());

        @(negedge i_clk);
        chk("rst_wr_en", o_dmem_wr_en, 1'b0);
        chk("rst_byte_sel", o_dmem_byte_sel, 4'h0);
        chk("rst_addr", o_dmem_addr, '0);
        chk("rst_data", o_dmem_data, 32'h0);
        chk("rst_rsp_valid", o_rsp_valid, 1'b0);
        chk("rst_rsp_err", o_rsp_err, 1'b0);
        chk("rst_rsp_rdata", o_rsp_rdata, 32'h0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_ready", o_req_ready, 1'b1);
        chk_en = 1'b1;

        // Aligned word store.
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        chk("sw_a1_addr", a1_addr, 6'd4);
        chk("sw_a1_sel", a1_sel, 4'b1111);
        chk("sw_a1_data", a1_data, 32'hDEAD_BEEF);
        chk("sw_a1_we", a1_we, 1'b1);
        chk("sw_latency", last_rsp_cyc - last_acc, 2);
        chk("sw_mem4", mem[4], 32'hDEAD_BEEF);

        // Sub-word loads with and without sign extension.
        set_word(4, 32'h80FF_7F01);
        do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0);
        chk("lb_rdata", last_rdata, 32'hFFFF_FFFF);
        chk("lb_a1_we", a1_we, 1'b0);
        do_req(1'b0, 2'd0, 1'b1, 32'h12, 32'h0);
        chk("lbu_rdata", last_rdata, 32'h0000_00FF);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        chk("lh_rdata", last_rdata, 32'hFFFF_80FF);
        chk("lh_latency", last_rsp_cyc - last_acc, 2);

        // Halfword store straddling words 4 and 5.
        do_req(1'b1, 2'd1, 1'b0, 32'h13, 32'h0000_ABCD);
        chk("sh_a1_addr", a1_addr, 6'd4);
        chk("sh_a1_sel", a1_sel, 4'b1000);
        chk("sh_a1_byte", a1_data[31:24], 8'hCD);
        chk("sh_a2_addr", a2_addr, 6'd5);
        chk("sh_a2_sel", a2_sel, 4'b0001);
        chk("sh_a2_byte", a2_data[7:0], 8'hAB);
        chk("sh_a2_we", a2_we, 1'b1);
        chk("sh_latency", last_rsp_cyc - last_acc, 3);
        chk("sh_mem4", mem[4], model_word(4));
        chk("sh_mem5", mem[5], model_word(5));
        do_req(1'b0, 2'd1, 1'b1, 32'h13, 32'h0);
        chk("lhu_cross", last_rdata, 32'h0000_ABCD);
        do_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0);
        chk("lh_cross", last_rdata, 32'hFFFF_ABCD);

        // Word load wrapping from the last word to word 0; high address bits ignored.
        set_word(NW - 1, 32'h1122_3344);
        set_word(0, 32'h5566_7788);
        do_req(1'b0, 2'd2, 1'b0, 32'h0001_00FE, 32'h0);
        chk("lw_wrap_a1_addr", a1_addr, 6'd63);
        chk("lw_wrap_a2_addr", a2_addr, 6'd0);
        chk("lw_wrap_rdata", last_rdata, 32'h7788_1122);
        chk("lw_wrap_latency", last_rsp_cyc - last_acc, 3);

        // Reserved size: error response, no memory write.
        w0 = wr_cnt;
        do_req(1'b1, 2'd3, 1'b0, 32'h20, 32'h1234_5678);
        chk("rsv_a1_we", a1_we, 1'b0);
        chk("rsv_a1_sel", a1_sel, 4'h0);
        chk("rsv_wr_cnt", wr_cnt, w0);
        chk("rsv_err", last_err, 1'b1);
        chk("rsv_rdata", last_rdata, 32'h0);
        chk("rsv_latency", last_rsp_cyc - last_acc, 1);

        // Short table of mixed accesses.
        for (int t = 0; t < 6; t++) begin
            do_req(tv_we[t], tv_sz[t], tv_uns[t], tv_adr[t], tv_wd[t]);
            chk($sformatf("tab%0d_rdata", t), last_rdata, tv_exp[t]);
        end
        chk("tab_mem9", mem[9], model_word(9));
        chk("tab_mem12", mem[12], model_word(12));

        // Reset during ACC1 of a crossing store: no ACC2, no response.
        @(negedge i_clk);
        chk_en = 1'b0;
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'd2; i_req_unsigned = 1'b0;
        i_req_addr = 32'h21; i_req_wdata = 32'h0102_0304;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        chk("abort_a1_addr", o_dmem_addr, 6'd8);
        chk("abort_a1_sel", o_dmem_byte_sel, 4'b1110);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("abort_wr_en", o_dmem_wr_en, 1'b0);
        chk("abort_sel", o_dmem_byte_sel, 4'h0);
        chk("abort_addr", o_dmem_addr, '0);
        chk("abort_data", o_dmem_data, 32'h0);
        chk("abort_rsp_valid", o_rsp_valid, 1'b0);
        w0 = wr_cnt;
        i_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk($sformatf("abort_ready%0d", k), o_req_ready, 1'b1);
            chk($sformatf("abort_no_rsp%0d", k), o_rsp_valid, 1'b0);
        end
        chk("abort_wr_cnt", wr_cnt, w0);
        chk("abort_mem9", mem[9], model_word(9));
        chk_en = 1'b1;

        do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
        chk("post_abort_latency", last_rsp_cyc - last_acc, 2);

        @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have parameter XLEN, default `XLEN (32): data width; only 32 is supported.
REQ-002 SHALL have parameter DMEM_ADDR_BIT, default `DMEM_ADDR_BIT: byte-address width of data memory.
REQ-003 SHALL have ports, in this order:
- i_clk  in  1  clock; all state updates on posedge.
- i_rst  in  1  reset; synchronous, active-high.
- i_req_valid  in  1  core request valid.
- o_req_ready  out  1  LSU can accept a request.
- i_req_we  in  1  1=store, 0=load.
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- i_req_unsigned  in  1  load zero-extends when 1.
- i_req_addr  in  XLEN  byte address.
- i_req_wdata  in  XLEN  store data, right-aligned.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_rdata  out  XLEN  extended load data; 0 for stores.
- o_rsp_err  out  1  reserved size, valid with o_rsp_valid.
- o_dmem_wr_en  out  1  memory write enable.
- o_dmem_byte_sel  out  XLEN/8  byte-lane enables.
- o_dmem_addr  out  DMEM_ADDR_BIT-2  word index.
- o_dmem_data  out  XLEN  lane-aligned write data.
- i_dmem_data  in  XLEN  memory word at o_dmem_addr, combinational read.

Function
REQ-004 SHALL implement states IDLE, ACC1, ACC2, RSP; o_req_ready=1 only in IDLE.
REQ-005 SHALL accept a request on a posedge in IDLE with i_req_valid=1, registering all request fields; the next state is ACC1, or RSP directly for size=11.
REQ-006 SHALL, in ACC1, drive o_dmem_addr=addr[DMEM_ADDR_BIT-1:2], byte_sel=(mask<<off)[3:0], data=wdata<<(8*off), wr_en=we; here off=addr[1:0] and mask=0001/0011/1111 for byte/half/word.
REQ-007 SHALL treat an access as crossing when off+bytes>4; ACC1 then goes to ACC2, otherwise to RSP.
REQ-008 SHALL, in ACC2, drive word index+1, wrapping from all-ones to 0; byte_sel=(mask<<off)[7:4]; data=wdata>>(8*(4-off)); wr_en=we.
REQ-009 SHALL capture i_dmem_data at the end of ACC1 and, where applicable, ACC2; the load result is the selected bytes right-justified: low bytes from ACC1, high bytes from ACC2.
REQ-010 SHALL sign-extend byte/half loads from bit 7/15 unless i_req_unsigned=1; word loads are unaffected.
REQ-011 SHALL assert o_rsp_valid for exactly one cycle in RSP, with o_rsp_rdata and o_rsp_err held stable that cycle, then return to IDLE.
REQ-012 SHALL, for size=11, perform no memory access and respond with o_rsp_err=1 and rdata=0.
REQ-013 SHALL drive o_dmem_wr_en=0 and o_dmem_byte_sel=0 in IDLE and RSP; o_dmem_addr holds its last value.
REQ-014 SHALL ignore address bits at and above DMEM_ADDR_BIT.
REQ-015 SHALL have latency acceptance-to-o_rsp_valid of 2 cycles when not crossing, 3 when crossing, 1 for reserved size.
REQ-016 SHALL accept no new request while busy; back-to-back requests are therefore separated by at least one RSP cycle.

Reset
REQ-017 SHALL, while i_rst=1, force state=IDLE, o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0, o_dmem_wr_en=0, o_dmem_byte_sel=0, o_dmem_addr=0, o_dmem_data=0.
REQ-018 SHALL abort any in-flight access on reset with no further memory write and no response; o_req_ready=1 from the first cycle after i_rst deasserts.

Structure
REQ-019 SHALL place size encodings (SZ_B/SZ_H/SZ_W) and state encodings as `define constants in riscv_configs.v.
REQ-020 SHALL use one combinational sub-module, riscv_lsu_align, computing byte_sel, shifted store data, and extended load data.

Verification
REQ-021 SHALL cover: sw addr=0x10 data=0xDEADBEEF -> ACC1 index 4, sel=1111, data 0xDEADBEEF; rsp 2 cycles after acceptance.
REQ-022 SHALL cover: mem[4]=0x80FF7F01, lb addr=0x12 -> rdata=0xFFFFFFFF; lbu -> 0x000000FF; lh addr=0x12 -> 0xFFFF80FF.
REQ-023 SHALL cover: sh addr=0x13 data=0xABCD -> ACC1 index 4 sel=1000 data[31:24]=0xCD; ACC2 index 5 sel=0001 data[7:0]=0xAB; rsp at 3 cycles.
REQ-024 SHALL cover: lw addr=(2^DMEM_ADDR_BIT)-2 -> ACC2 index wraps to 0; result combines upper half of last word with lower half of word 0.
REQ-025 SHALL cover: size=11 request -> no wr_en, o_rsp_err=1 one cycle after acceptance.
REQ-026 SHALL cover: i_rst asserted during ACC1 of a crossing store -> no ACC2 write, no rsp, o_req_ready=1 on the cycle after reset deasserts.
